// File: rtl/eeg_moving_avg_filter_if.sv
// Sample-stream interface between the EEG ADC side and the moving-average filter.
//   in_valid / in_sample / flush           : producer -> filter
//   out_valid / out_sample / warm / artifact_flag : filter -> detector
// The master modport is the producer/consumer side; the slave modport is the filter.
interface eeg_moving_avg_filter_if #(
   parameter int unsigned DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_sample;
   logic              flush;
   logic              out_valid;
   logic [DATA_W-1:0] out_sample;
   logic              warm;
   logic              artifact_flag;

   modport master (
      output in_valid, in_sample, flush,
      input  out_valid, out_sample, warm, artifact_flag
   );

   modport slave (
      input  in_valid, in_sample, flush,
      output out_valid, out_sample, warm, artifact_flag
   );
endinterface

// File: rtl/eeg_moving_avg_filter.sv
// Boxcar (2^LOG2_TAPS-point moving-average) filter for the raw EEG sample stream
// feeding the P300 detector. Output is suppressed until the window is full.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : eeg_moving_avg_filter_if.slave
//              in_valid/in_sample/flush in, out_valid/out_sample/warm/artifact_flag out
// Optional feature: define EEG_ARTIFACT_REJECT_EN to replace samples above
// ARTIFACT_LIMIT with the last accepted sample and pulse artifact_flag.
module eeg_moving_avg_filter #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned LOG2_TAPS      = 3,
   parameter int unsigned ARTIFACT_LIMIT = 200
) (
   input logic                    clk,
   input logic                    reset_n,
   eeg_moving_avg_filter_if.slave bus
);

   localparam int unsigned TAPS  = 1 << LOG2_TAPS;
   localparam int unsigned SUM_W = DATA_W + LOG2_TAPS;
   localparam logic [DATA_W-1:0] LIMIT = DATA_W'(ARTIFACT_LIMIT);

   typedef enum logic {FILL, RUN} state_t;

   state_t                 state, state_d;
   logic [DATA_W-1:0]      win [TAPS];
   logic [SUM_W-1:0]       sum, sum_d, new_sum;
   logic [LOG2_TAPS-1:0]   wr_ptr, wr_ptr_d;
   logic [LOG2_TAPS-1:0]   fill_cnt, fill_cnt_d;
   logic                   warm, warm_d;
   logic                   out_valid, out_valid_d;
   logic [DATA_W-1:0]      out_sample, out_sample_d;
   logic                   art_flag, art_flag_d;
   logic                   win_we, win_clr;
   logic [DATA_W-1:0]      s_eff;
   logic                   is_art;
   logic [DATA_W-1:0]      avg;

`ifdef EEG_ARTIFACT_REJECT_EN
   logic [DATA_W-1:0] last_s;
   logic              has_last;

   // Out-of-range samples are replaced by the last accepted one (0 if none yet)
   always_comb begin
      is_art = bus.in_sample > LIMIT;
      s_eff  = bus.in_sample;
      if (is_art) s_eff = has_last ? last_s : '0;
   end

   // Last accepted sample since reset/flush
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_s   <= '0;
         has_last <= 1'b0;
      end else if (bus.flush) begin
         last_s   <= '0;
         has_last <= 1'b0;
      end else if (bus.in_valid) begin
         last_s   <= s_eff;
         has_last <= 1'b1;
      end
   end
`else
   logic limit_unused;

   assign limit_unused = bus.in_sample > LIMIT;
   assign s_eff        = bus.in_sample;
   assign is_art       = 1'b0;
`endif

   // Running sum already contains win[wr_ptr], so the subtraction never underflows
   assign new_sum = sum + SUM_W'(s_eff) - SUM_W'(win[wr_ptr]);
   assign avg     = DATA_W'(new_sum >> LOG2_TAPS);

   // Next-state and output logic
   always_comb begin
      state_d      = state;
      sum_d        = sum;
      wr_ptr_d     = wr_ptr;
      fill_cnt_d   = fill_cnt;
      warm_d       = warm;
      out_valid_d  = 1'b0;
      out_sample_d = out_sample;
      art_flag_d   = 1'b0;
      win_we       = 1'b0;
      win_clr      = 1'b0;

      if (bus.flush) begin
         state_d    = FILL;
         sum_d      = '0;
         wr_ptr_d   = '0;
         fill_cnt_d = '0;
         warm_d     = 1'b0;
         win_clr    = 1'b1;
      end else if (bus.in_valid) begin
         sum_d      = new_sum;
         wr_ptr_d   = wr_ptr + LOG2_TAPS'(1);
         win_we     = 1'b1;
         art_flag_d = is_art;
         case (state)
            FILL: begin
               fill_cnt_d = fill_cnt + LOG2_TAPS'(1);
               if (fill_cnt == LOG2_TAPS'(TAPS - 1)) begin
                  state_d      = RUN;
                  warm_d       = 1'b1;
                  out_valid_d  = 1'b1;
                  out_sample_d = avg;
               end
            end
            RUN: begin
               out_valid_d  = 1'b1;
               out_sample_d = avg;
            end
            default: state_d = FILL;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= FILL;
         sum        <= '0;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         warm       <= 1'b0;
         out_valid  <= 1'b0;
         out_sample <= '0;
         art_flag   <= 1'b0;
         for (int i = 0; i < int'(TAPS); i++) win[i] <= '0;
      end else begin
         state      <= state_d;
         sum        <= sum_d;
         wr_ptr     <= wr_ptr_d;
         fill_cnt   <= fill_cnt_d;
         warm       <= warm_d;
         out_valid  <= out_valid_d;
         out_sample <= out_sample_d;
         art_flag   <= art_flag_d;
         if (win_clr) begin
            for (int i = 0; i < int'(TAPS); i++) win[i] <= '0;
         end else if (win_we) begin
            win[wr_ptr] <= s_eff;
         end
      end
   end

   assign bus.out_valid     = out_valid;
   assign bus.out_sample    = out_sample;
   assign bus.warm          = warm;
   assign bus.artifact_flag = art_flag;

endmodule

// File: tb/tb_eeg_moving_avg_filter.sv
// Directed self-checking bench for eeg_moving_avg_filter (default TAPS=8).
module tb_eeg_moving_avg_filter;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   eeg_moving_avg_filter_if #(.DATA_W(8)) bus ();

   eeg_moving_avg_filter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample; on return we are one cycle later with the result visible
   task automatic drive(input int s, input int ev, input int es, input string tag);
      bus.in_valid  = 1'b1;
      bus.in_sample = 8'(s);
      bus.flush     = 1'b0;
      @(negedge clk);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
      check({tag, "_sample"}, 32'(bus.out_sample), 32'(es));
   endtask

   task automatic idle(input int n, input int es, input string tag);
      bus.in_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check({tag, "_gap_valid"}, 32'(bus.out_valid), 32'd0);
         check({tag, "_gap_hold"}, 32'(bus.out_sample), 32'(es));
      end
   endtask

   task automatic do_flush(input int es, input string tag);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check({tag, "_flush_warm"}, 32'(bus.warm), 32'd0);
      check({tag, "_flush_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_flush_hold"}, 32'(bus.out_sample), 32'(es));
   endtask

   int t2_exp [8] = '{55, 60, 65, 70, 75, 80, 85, 90};
   int t3_gap [8] = '{0, 1, 2, 3, 4, 5, 0, 2};
   int t4_in  [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
   int t4_exp [8] = '{0, 0, 0, 1, 1, 2, 3, 4};
   int t4_wrap[16] = '{5, 6, 6, 7, 7, 7, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
   int prev;
   int art_exp_sample;
   int art_exp_flag;

   initial begin
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sample = '0;
      bus.flush     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sample", 32'(bus.out_sample), 32'd0);
      check("rst_warm", 32'(bus.warm), 32'd0);
      check("rst_art", 32'(bus.artifact_flag), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Warm-up
      for (int i = 0; i < 7; i++) drive(50, 0, 0, "t1_fill");
      check("t1_warm_pre", 32'(bus.warm), 32'd0);
      drive(50, 1, 50, "t1_full");
      check("t1_warm", 32'(bus.warm), 32'd1);

      // Step response
      for (int i = 0; i < 8; i++) drive(90, 1, t2_exp[i], "t2_step");
      drive(90, 1, 90, "t2_steady");
      idle(1, 90, "t2");

      // Gapped input
      do_flush(90, "t3");
      for (int i = 0; i < 7; i++) drive(50, 0, 90, "t3_fill");
      drive(50, 1, 50, "t3_full");
      prev = 50;
      for (int i = 0; i < 8; i++) begin
         idle(t3_gap[i], prev, "t3");
         drive(90, 1, t2_exp[i], "t3_step");
         prev = t2_exp[i];
      end

      // Truncation and pointer wrap across several windows
      do_flush(90, "t4");
      for (int i = 0; i < 7; i++) drive(0, 0, 90, "t4_fill");
      drive(0, 1, 0, "t4_full");
      for (int i = 0; i < 8; i++) drive(t4_in[i], 1, t4_exp[i], "t4_trunc");
      for (int i = 0; i < 16; i++) drive(8, 1, t4_wrap[i], "t4_wrap");

      // Flush together with a valid sample: sample dropped
      bus.in_valid  = 1'b1;
      bus.in_sample = 8'd200;
      bus.flush     = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("t5_fl_valid", 32'(bus.out_valid), 32'd0);
      check("t5_fl_warm", 32'(bus.warm), 32'd0);
      check("t5_fl_hold", 32'(bus.out_sample), 32'd8);
      for (int i = 0; i < 7; i++) drive(40, 0, 8, "t5_refill");
      check("t5_warm_pre", 32'(bus.warm), 32'd0);
      drive(40, 1, 40, "t5_full");
      check("t5_warm", 32'(bus.warm), 32'd1);

      // Asynchronous reset mid-window
      for (int i = 0; i < 3; i++) drive(40, 1, 40, "t5_run");
      bus.in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("t5_arst_valid", 32'(bus.out_valid), 32'd0);
      check("t5_arst_sample", 32'(bus.out_sample), 32'd0);
      check("t5_arst_warm", 32'(bus.warm), 32'd0);
      check("t5_arst_art", 32'(bus.artifact_flag), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 7; i++) drive(20, 0, 0, "t5_post");
      drive(20, 1, 20, "t5_post_full");

      // Artifact sample
`ifdef EEG_ARTIFACT_REJECT_EN
      art_exp_sample = 60;
      art_exp_flag   = 1;
`else
      art_exp_sample = 84;
      art_exp_flag   = 0;
`endif
      do_flush(20, "t6");
      for (int i = 0; i < 7; i++) drive(60, 0, 20, "t6_fill");
      drive(60, 1, 60, "t6_full");
      check("t6_art_pre", 32'(bus.artifact_flag), 32'd0);
      drive(255, 1, art_exp_sample, "t6_art");
      check("t6_art_flag", 32'(bus.artifact_flag), 32'(art_exp_flag));
      idle(1, art_exp_sample, "t6");
      check("t6_art_clear", 32'(bus.artifact_flag), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
